// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Multiplexed seven-segment display driver for common-anode, active-low
// hardware. Each digit of a packed hex value is scanned in turn. A
// prescaler sets how long each digit slot lasts. Digit 0 of every frame is
// rendered from the live inputs. At that same instant the inputs are
// captured into shadow registers, and the remaining digits of the frame are
// rendered from those shadows, so a frame is never torn.
//
// Parameters
//   DIGITS     number of digits scanned (1..16)
//   SCAN_DIV   clock cycles per digit slot (>=1)
//   BLINK_DIV  full frames per blink half-period (>=1)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset (has priority over en)
//   en          display enable; 0 blanks outputs and parks the scan state
//   data        hex value, nibble i drives digit i
//   dp_mask     bit i lights the decimal point of digit i
//   blank_lz    1 blanks digits above the most-significant nonzero nibble
//   blink_mask  bit i makes digit i blink
//   AN          digit enables, active-low, one-hot-low when lit
//   SEG         segments, active-low, {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_scan_display #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEG
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int CW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Glyph for one hex nibble, dp segment off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Scan state
    logic [PW-1:0]         r_pcnt;
    logic [CW-1:0]         r_cur;
    logic [FW-1:0]         r_fcnt;
    logic                  r_started;   // at least one frame has begun since reset/enable
    logic                  r_bphase;

    // Frame snapshot
    logic [4*DIGITS-1:0]   r_sh_data;
    logic [DIGITS-1:0]     r_sh_dp;
    logic [DIGITS-1:0]     r_sh_blink;

    // Output registers
    logic [DIGITS-1:0]     r_an;
    logic [7:0]            r_seg;

    logic                  w_tick;
    logic                  w_cur_zero;
    logic                  w_frame_start;
    logic                  w_last;
    logic [4*DIGITS-1:0]   w_fr_data;
    logic [DIGITS-1:0]     w_fr_dp;
    logic [DIGITS-1:0]     w_fr_blink;
    logic [3:0]            w_nib;
    logic [CW-1:0]         w_msnz;
    logic                  w_blink_done;
    logic                  w_bphase_eff;
    logic                  w_blank;
    logic [7:0]            w_seg_lit;
    logic [DIGITS-1:0]     w_an_lit;

    assign w_tick        = (r_pcnt == PW'(SCAN_DIV - 1));
    assign w_cur_zero    = (r_cur == '0);
    assign w_frame_start = w_tick && w_cur_zero;
    assign w_last        = (r_cur == CW'(DIGITS - 1));

    // Digit 0 renders from the live inputs; later digits from the snapshot
    // that was taken on the same tick that rendered digit 0.
    assign w_fr_data  = w_cur_zero ? data       : r_sh_data;
    assign w_fr_dp    = w_cur_zero ? dp_mask    : r_sh_dp;
    assign w_fr_blink = w_cur_zero ? blink_mask : r_sh_blink;

    assign w_nib = w_fr_data[{r_cur, 2'b00} +: 4];

    // Index of the most-significant nonzero nibble; 0 when the value is zero,
    // which keeps digit 0 lit for an all-zero value.
    always_comb begin
        w_msnz = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (w_fr_data[4*i +: 4] != 4'h0) begin
                w_msnz = CW'(i);
            end
        end
    end

    // The frame-start tick that completes BLINK_DIV frames flips the phase,
    // and the digit rendered on that tick already sees the new phase.
    assign w_blink_done = r_started && (r_fcnt == FW'(BLINK_DIV - 1));
    assign w_bphase_eff = r_bphase ^ (w_frame_start && w_blink_done);

    assign w_blank   = (blank_lz && (r_cur > w_msnz)) ||
                       (w_fr_blink[r_cur] && w_bphase_eff);
    assign w_seg_lit = hex_glyph(w_nib) & {~w_fr_dp[r_cur], 7'h7F};
    assign w_an_lit  = ~(DIGITS'(1) << r_cur);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt     <= '0;
            r_cur      <= '0;
            r_fcnt     <= '0;
            r_started  <= 1'b0;
            r_bphase   <= 1'b0;
            r_sh_data  <= '0;
            r_sh_dp    <= '0;
            r_sh_blink <= '0;
            r_an       <= '1;
            r_seg      <= 8'hFF;
        end else if (!en) begin
            r_pcnt     <= '0;
            r_cur      <= '0;
            r_fcnt     <= '0;
            r_started  <= 1'b0;
            r_bphase   <= 1'b0;
            r_an       <= '1;
            r_seg      <= 8'hFF;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                if (w_blank) begin
                    r_an  <= '1;
                    r_seg <= 8'hFF;
                end else begin
                    r_an  <= w_an_lit;
                    r_seg <= w_seg_lit;
                end
                r_cur <= w_last ? '0 : r_cur + 1'b1;
                if (w_cur_zero) begin
                    r_sh_data  <= data;
                    r_sh_dp    <= dp_mask;
                    r_sh_blink <= blink_mask;
                    // The first frame start only marks that scanning has begun;
                    // every later one closes a completed frame.
                    if (r_started) begin
                        r_fcnt   <= w_blink_done ? '0 : r_fcnt + 1'b1;
                        r_bphase <= w_bphase_eff;
                    end else begin
                        r_started <= 1'b1;
                    end
                end
            end
        end
    end

    assign AN  = r_an;
    assign SEG = r_seg;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [7:0]  seg;

  logic        rst1;
  logic        en1;
  logic [3:0]  data1;
  logic [0:0]  dp1;
  logic [0:0]  blink1;
  logic [0:0]  an1;
  logic [7:0]  seg1;

  int n_checks;
  int n_errors;

  logic [7:0] glyph_tab [16];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  seg_scan_display #(.DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .AN         (an),
    .SEG        (seg)
  );

  seg_scan_display #(.DIGITS(1), .SCAN_DIV(1), .BLINK_DIV(2)) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .en         (en1),
    .data       (data1),
    .dp_mask    (dp1),
    .blank_lz   (1'b0),
    .blink_mask (blink1),
    .AN         (an1),
    .SEG        (seg1)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
    check({tag, ".an"}, {8'h00, an}, {8'h00, exp_an});
    check({tag, ".seg"}, {8'h00, seg}, {8'h00, exp_seg});
  endtask

  // ---------------- drivers ----------------
  // Advance n cycles; returns at a falling edge so outputs are stable.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] v;
    v = 8'h01 << d;
    return ~v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    glyph_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    rst = 1'b1; en = 1'b1; data = 32'h7654_3210; dp_mask = 8'h00;
    blank_lz = 1'b0; blink_mask = 8'h00;
    rst1 = 1'b1; en1 = 1'b1; data1 = 4'hF; dp1 = 1'b0; blink1 = 1'b0;

    // Reset state
    cyc(2);
    check_out("reset", 8'hFF, 8'hFF);
    check("reset1.an", {15'd0, an1}, 16'h0001);
    check("reset1.seg", {8'h00, seg1}, 16'h00FF);

    // Basic scan 76543210
    rst = 1'b0;
    cyc(3);
    check_out("scan.pre", 8'hFF, 8'hFF);
    cyc(1);
    check_out("scan.d0", 8'hFE, 8'hC0);
    cyc(2);
    check_out("scan.d0hold", 8'hFE, 8'hC0);
    cyc(2);
    for (int d = 1; d < 8; d++) begin
      check_out($sformatf("scan.d%0d", d), an_of(d), glyph_tab[d]);
      cyc(4);
    end
    check_out("scan.wrap", 8'hFE, 8'hC0);

    // Leading-zero blanking with decimal point
    data = 32'h0000_002A; blank_lz = 1'b1; dp_mask = 8'h02;
    apply_reset();
    cyc(4);
    check_out("lz.d0", 8'hFE, 8'h88);
    cyc(4);
    check_out("lz.d1", 8'hFD, 8'h24);
    for (int d = 2; d < 8; d++) begin
      cyc(4);
      check_out($sformatf("lz.d%0d", d), 8'hFF, 8'hFF);
    end

    // All-zero value: single 0, digit 1 blanked including its dp
    data = 32'h0;
    apply_reset();
    cyc(4);
    check_out("zero.d0", 8'hFE, 8'hC0);
    cyc(4);
    check_out("zero.d1", 8'hFF, 8'hFF);
    blank_lz = 1'b0; dp_mask = 8'h00;
    apply_reset();
    cyc(8);
    check_out("zero.nolz.d1", 8'hFD, 8'hC0);

    // Blink on digit 0
    data = 32'h0000_0008; blink_mask = 8'h01;
    apply_reset();
    cyc(4);
    check_out("blink.f0", 8'hFE, 8'h80);
    cyc(32);
    check_out("blink.f1", 8'hFE, 8'h80);
    cyc(32);
    check_out("blink.f2", 8'hFF, 8'hFF);
    cyc(4);
    check_out("blink.f2.d1", 8'hFD, 8'hC0);
    cyc(28);
    check_out("blink.f3", 8'hFF, 8'hFF);
    cyc(32);
    check_out("blink.f4", 8'hFE, 8'h80);
    blink_mask = 8'h00;

    // Mid-frame data change is not torn
    data = 32'h1111_1111;
    apply_reset();
    cyc(4);
    check_out("tear.d0", 8'hFE, 8'hF9);
    cyc(12);
    check_out("tear.d3", 8'hF7, 8'hF9);
    cyc(1);
    data = 32'h2222_2222;
    cyc(3);
    for (int d = 4; d < 8; d++) begin
      check_out($sformatf("tear.old.d%0d", d), an_of(d), 8'hF9);
      cyc(4);
    end
    for (int d = 0; d < 8; d++) begin
      check_out($sformatf("tear.new.d%0d", d), an_of(d), 8'hA4);
      cyc(4);
    end

    // Enable drop mid-slot
    data = 32'h7654_3210;
    apply_reset();
    cyc(24);
    check_out("en.d5", 8'hDF, 8'h92);
    cyc(1);
    en = 1'b0;
    cyc(1);
    check_out("en.off", 8'hFF, 8'hFF);
    cyc(10);
    check_out("en.held", 8'hFF, 8'hFF);
    en = 1'b1;
    cyc(3);
    check_out("en.pre", 8'hFF, 8'hFF);
    cyc(1);
    check_out("en.d0", 8'hFE, 8'hC0);
    cyc(4);
    check_out("en.d1", 8'hFD, 8'hF9);

    // Reset mid-slot
    cyc(16);
    check_out("rst.d5", 8'hDF, 8'h92);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check_out("rst.off", 8'hFF, 8'hFF);
    rst = 1'b0;
    cyc(3);
    check_out("rst.pre", 8'hFF, 8'hFF);
    cyc(1);
    check_out("rst.d0", 8'hFE, 8'hC0);

    // Single digit, one cycle per slot
    rst1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      check($sformatf("one.an.c%0d", c), {15'd0, an1}, 16'h0000);
      check($sformatf("one.seg.c%0d", c), {8'h00, seg1}, 16'h008E);
    end
    data1 = 4'h3;
    cyc(1);
    check("one.seg.3", {8'h00, seg1}, 16'h00B0);
    dp1 = 1'b1;
    cyc(1);
    check("one.seg.3dp", {8'h00, seg1}, 16'h0030);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
